// File: rtl/morphle_pkg.sv
// Shared definitions for the morphle cell array: config codes, dual-rail values,
// and the per-cell config width.
package morphle_pkg;
  localparam int CBITS = 3;

  typedef enum logic [CBITS-1:0] {
    CFG_SPACE = 3'b000,
    CFG_PLUS  = 3'b001,
    CFG_MINUS = 3'b010,
    CFG_VBAR  = 3'b011,
    CFG_ONE   = 3'b100,
    CFG_ZERO  = 3'b101,
    CFG_Y     = 3'b110,
    CFG_N     = 3'b111
  } cfg_e;

  localparam logic [1:0] VEMPTY = 2'd0;
  localparam logic [1:0] V0     = 2'd1;
  localparam logic [1:0] V1     = 2'd2;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/ycloader_if.sv
// Row handshake between a config source and the ycloader.
interface ycloader_if
  import morphle_pkg::*;
#(
  parameter int BLOCKWIDTH = 8
);
  logic [CBITS*BLOCKWIDTH-1:0] row_data;
  logic                        row_valid;
  logic                        row_ready;

  modport master (output row_data, output row_valid, input  row_ready);
  modport slave  (input  row_data, input  row_valid, output row_ready);
endinterface

// File: rtl/ycrowser.sv
// Row register plus per-column MSB-first bit select feeding the cbitin bus.
module ycrowser
  import morphle_pkg::*;
#(
  parameter int BLOCKWIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic [CBITS*BLOCKWIDTH-1:0] din,
  input  logic                        upd,
  input  logic                        clr,
  input  logic [1:0]                  sel,
  output logic [BLOCKWIDTH-1:0]       cbitin
);
  logic [CBITS*BLOCKWIDTH-1:0] row_reg;
  logic [CBITS*BLOCKWIDTH-1:0] src;
  logic [BLOCKWIDTH-1:0]       nxt;

  // First bit of a row is taken straight from the incoming data on accept.
  assign src = load ? din : row_reg;

  for (genvar x = 0; x < BLOCKWIDTH; x++) begin : g_col
    assign nxt[x] = src[CBITS*x + CBITS - 1 - int'(sel)];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_reg <= '0;
      cbitin  <= '0;
    end else begin
      if (load) row_reg <= din;
      if (clr)      cbitin <= '0;
      else if (upd) cbitin <= nxt;
    end
  end
endmodule

// File: rtl/ycloader.sv
// Serialises rows of cell config codes onto a yblock's cbitin/confclk port,
// holding the array in reset until a full load completes.
module ycloader
  import morphle_pkg::*;
#(
  parameter int BLOCKWIDTH  = 8,
  parameter int BLOCKHEIGHT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  ycloader_if.slave             rowif,
  output logic                  confclk,
  output logic [BLOCKWIDTH-1:0] cbitin,
  output logic                  array_reset,
  output logic                  busy,
  output logic                  done
);
  localparam int RW = clog2_min1(BLOCKHEIGHT);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_STROBE = 3'd3;
  localparam logic [2:0] S_REL    = 3'd4;

  logic [2:0]    state;
  logic [RW-1:0] rowcnt;
  logic [1:0]    bitcnt;
  logic          accept, last_bit, last_row, upd, clr;
  logic [1:0]    sel;

  assign accept   = (state == S_WAIT) && rowif.row_valid;
  assign last_bit = (bitcnt == 2'd2);
  assign last_row = (rowcnt == RW'(BLOCKHEIGHT - 1));
  // cbitin is loaded on entry to SETUP so it settles a full clk before confclk rises.
  assign upd      = accept || ((state == S_STROBE) && !last_bit);
  assign clr      = (state == S_STROBE) && last_bit && last_row;
  assign sel      = accept ? 2'd0 : bitcnt + 2'd1;

  assign confclk         = (state == S_STROBE);
  assign rowif.row_ready = (state == S_WAIT);
  assign done            = (state == S_REL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      rowcnt      <= '0;
      bitcnt      <= '0;
      array_reset <= 1'b1;
      busy        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state       <= S_WAIT;
          array_reset <= 1'b1;
          busy        <= 1'b1;
          rowcnt      <= '0;
        end
        S_WAIT: if (rowif.row_valid) begin
          bitcnt <= '0;
          state  <= S_SETUP;
        end
        S_SETUP: state <= S_STROBE;
        S_STROBE: begin
          if (!last_bit) begin
            bitcnt <= bitcnt + 2'd1;
            state  <= S_SETUP;
          end else if (!last_row) begin
            rowcnt <= rowcnt + RW'(1);
            state  <= S_WAIT;
          end else begin
            state       <= S_REL;
            array_reset <= 1'b0;
            busy        <= 1'b0;
          end
        end
        S_REL:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  ycrowser #(.BLOCKWIDTH(BLOCKWIDTH)) u_rowser (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .din    (rowif.row_data),
    .upd    (upd),
    .clr    (clr),
    .sel    (sel),
    .cbitin (cbitin)
  );
endmodule

// File: tb/tb_ycloader.sv
// Bench for ycloader: 8x8 loads with random rows, stalls, restart and mid-load
// reset, plus a 2x1 instance for bit-order vectors.
module tb_ycloader;
  import morphle_pkg::*;
  localparam int W = 8, H = 8, RWID = CBITS*W;

  logic clk = 1'b0;
  logic reset, start, start2;
  logic confclk, array_reset, busy, done;
  logic [W-1:0] cbitin;
  logic confclk2, ar2, busy2, done2;
  logic [1:0] cbitin2;

  ycloader_if #(.BLOCKWIDTH(W)) rif ();
  ycloader_if #(.BLOCKWIDTH(2)) rif2 ();

  ycloader #(.BLOCKWIDTH(W), .BLOCKHEIGHT(H)) dut (
    .clk(clk), .reset(reset), .start(start), .rowif(rif), .confclk(confclk),
    .cbitin(cbitin), .array_reset(array_reset), .busy(busy), .done(done));

  ycloader #(.BLOCKWIDTH(2), .BLOCKHEIGHT(1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .rowif(rif2), .confclk(confclk2),
    .cbitin(cbitin2), .array_reset(ar2), .busy(busy2), .done(done2));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Observation of the yblock-facing port, sampled on the falling edge.
  logic [W-1:0] capq[$];
  int dbl, unst, ndone, stall_viol, stalled;
  logic prev_cc;
  logic [W-1:0] prev_cb;
  logic [RWID-1:0] rows [H];

  task automatic tick();
    @(negedge clk);
    if (confclk) begin
      if (prev_cc) dbl++;
      if (cbitin !== prev_cb) unst++;
      capq.push_back(cbitin);
    end
    if (done) ndone++;
    prev_cc = confclk;
    prev_cb = cbitin;
  endtask

  task automatic run_load(input int stall_row, input int stall_len, input int restart_row,
                          input int abort_pulses, output int done_cyc);
    int r, cyc;
    logic acc, prev_ar, prev_busy;
    bit restarted;
    capq.delete();
    dbl = 0; unst = 0; ndone = 0; stall_viol = 0; stalled = 0;
    prev_cc = 1'b0; prev_cb = cbitin;
    done_cyc = -1; r = 0; restarted = 0;
    start = 1'b1; rif.row_valid = 1'b1; rif.row_data = rows[0];
    tick();
    start = 1'b0; cyc = 1;
    while (cyc < 600) begin
      if (r == stall_row && stalled > 0 && stalled < stall_len && !rif.row_ready) stall_viol++;
      if (r == stall_row && stalled < stall_len && (stalled > 0 || rif.row_ready)) begin
        rif.row_valid = 1'b0;
        stalled++;
        if (confclk) stall_viol++;
      end else begin
        rif.row_valid = (r < H);
        rif.row_data  = rows[(r < H) ? r : 0];
      end
      start = 1'b0;
      if (r == restart_row && !restarted) begin start = 1'b1; restarted = 1; end
      acc = rif.row_valid && rif.row_ready;
      prev_ar = array_reset; prev_busy = busy;
      tick();
      cyc++;
      if (acc) r++;
      if (abort_pulses > 0 && capq.size() >= abort_pulses) break;
      if (ndone > 0 && done_cyc < 0) begin
        done_cyc = cyc;
        check("arst_at_done", {63'd0, array_reset}, 64'd0);
        check("arst_before_done", {63'd0, prev_ar}, 64'd1);
        check("busy_before_done", {63'd0, prev_busy}, 64'd1);
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    start = 1'b0; rif.row_valid = 1'b0;
  endtask

  // A yblock column shifts bits upward, so row r's cell code is the three bits of
  // pulses 3r..3r+2 in order, MSB first.
  task automatic verify(input string tag, input int dc, input int exp_dc);
    logic [RWID-1:0] rec;
    check({tag, "_done_cyc"}, dc, exp_dc);
    check({tag, "_pulses"}, capq.size(), 24);
    check({tag, "_ndone"}, ndone, 1);
    check({tag, "_dbl_high"}, dbl, 0);
    check({tag, "_cbit_unstable"}, unst, 0);
    check({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
    if (capq.size() == 24) begin
      for (int r = 0; r < H; r++) begin
        for (int x = 0; x < W; x++)
          for (int b = 0; b < CBITS; b++)
            rec[CBITS*x + 2 - b] = capq[CBITS*r + b][x];
        check($sformatf("%s_row%0d", tag, r), rec, rows[r]);
      end
    end
  endtask

  task automatic rand_rows();
    for (int i = 0; i < H; i++) rows[i] = RWID'($urandom);
  endtask

  typedef struct {
    logic [5:0] d;
    logic [1:0] e [3];
  } vec_t;
  vec_t vt [4];

  initial begin
    int dc, chg, slen, srow;
    logic [1:0] cap2 [$];
    int dc2;
    vt[0].d = 6'b110_011; vt[0].e = '{2'b10, 2'b11, 2'b01};
    vt[1].d = 6'b000_111; vt[1].e = '{2'b01, 2'b01, 2'b01};
    vt[2].d = 6'b101_010; vt[2].e = '{2'b10, 2'b01, 2'b10};
    vt[3].d = 6'b100_001; vt[3].e = '{2'b10, 2'b00, 2'b01};

    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    rif.row_valid = 1'b0; rif.row_data = '0;
    rif2.row_valid = 1'b0; rif2.row_data = '0;
    repeat (3) @(negedge clk);
    check("rst_array_reset", {63'd0, array_reset}, 64'd1);
    check("rst_confclk", {63'd0, confclk}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_row_ready", {63'd0, rif.row_ready}, 64'd0);
    check("rst_done_cbitin", {55'd0, done, cbitin}, 64'd0);

    // Idle after reset, with row_valid asserted outside WAIT_ROW.
    reset = 1'b0; rif.row_valid = 1'b1; chg = 0;
    repeat (20) begin
      tick();
      if ({array_reset, confclk, busy, rif.row_ready, done, cbitin} !== {1'b1, 4'b0, {W{1'b0}}}) chg++;
    end
    check("idle_unchanged", chg, 0);
    rif.row_valid = 1'b0;

    for (int i = 0; i < H; i++) rows[i] = 24'h249249;
    run_load(-1, 0, -1, 0, dc);
    verify("plus", dc, 57);

    rand_rows();
    run_load(3, 10, -1, 0, dc);
    verify("stall", dc, 67);
    check("stall_viol", stall_viol, 0);
    check("stall_len", stalled, 10);

    // Reset right after the 5th pulse.
    rand_rows();
    run_load(-1, 0, -1, 5, dc);
    check("abort_pulses", capq.size(), 5);
    reset = 1'b1;
    #1;
    check("abort_confclk", {63'd0, confclk}, 64'd0);
    check("abort_arst", {63'd0, array_reset}, 64'd1);
    check("abort_busy_ready", {62'd0, busy, rif.row_ready}, 64'd0);
    tick();
    reset = 1'b0; ndone = 0;
    repeat (10) tick();
    check("abort_no_done", ndone, 0);
    check("abort_arst_held", {63'd0, array_reset}, 64'd1);
    rand_rows();
    run_load(-1, 0, -1, 0, dc);
    verify("after_abort", dc, 57);

    rand_rows();
    run_load(-1, 0, 1, 0, dc);
    verify("restart", dc, 57);

    for (int k = 0; k < 3; k++) begin
      rand_rows();
      srow = $urandom_range(0, H-1);
      slen = $urandom_range(0, 6);
      run_load(srow, slen, -1, 0, dc);
      verify($sformatf("rnd%0d", k), dc, 57 + slen);
    end

    // Bit order on a one-row, two-column loader.
    foreach (vt[i]) begin
      cap2.delete(); dc2 = -1;
      start2 = 1'b1; rif2.row_valid = 1'b1; rif2.row_data = vt[i].d;
      for (int c = 1; c < 40 && dc2 < 0; c++) begin
        @(negedge clk);
        start2 = 1'b0;
        if (confclk2) cap2.push_back(cbitin2);
        if (done2) dc2 = c;
      end
      rif2.row_valid = 1'b0;
      check($sformatf("bo%0d_pulses", i), cap2.size(), 3);
      check($sformatf("bo%0d_done_cyc", i), dc2, 8);
      if (cap2.size() == 3)
        for (int b = 0; b < 3; b++)
          check($sformatf("bo%0d_bit%0d", i, b), {62'd0, cap2[b]}, {62'd0, vt[i].e[b]});
      repeat (2) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
